// File: rtl/vec_lane_pkg.sv
// Package shared by the lane loader and its fan-out.
// Holds the loader state enum and the helper that sizes the lane index.
package vec_lane_pkg;

    // LOAD collects serial samples; SCAN sweeps the lane index.
    typedef enum logic {
        StLoad = 1'b0,
        StScan = 1'b1
    } state_e;

    // Width of a lane index for n lanes (n is 2..16).
    function automatic int unsigned sel_width(input int unsigned n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/vec_lane_fanout.sv
// Purely structural fan-out of the single lane register into the three
// shapes the consumer may index. Because all three come from one source
// they cannot diverge.
// Ports:
//   lanes_i     packed lane register, bit i is lane i
//   lane_vec_o  packed copy
//   lane_arr_o  unpacked array of 1-bit vectors
//   lane_bit_o  unpacked array of bits
module vec_lane_fanout #(
    parameter int unsigned NLANES = 4
) (
    input  logic [NLANES-1:0] lanes_i,
    output logic [NLANES-1:0] lane_vec_o,
    output logic [0:0]        lane_arr_o [NLANES],
    output bit                lane_bit_o [NLANES]
);

    assign lane_vec_o = lanes_i;

    for (genvar i = 0; i < NLANES; i++) begin : g_lane
        assign lane_arr_o[i] = lanes_i[i +: 1];
        assign lane_bit_o[i] = lanes_i[i];
    end

endmodule

// File: rtl/vec_lane_loader.sv
// Serial lane loader. Collects NLANES single-bit samples into a lane
// buffer, then sweeps a lane index over the filled buffer with a
// valid/ready handshake. Every output is registered.
// Ports:
//   clk, reset               clock, synchronous active-high reset
//   in_valid_i, in_bit_i     serial sample input
//   in_ready_o               loader accepts a sample this cycle
//   flush_i                  synchronous abort of the current load/sweep
//   lane_vec_o/arr_o/bit_o   lane buffer in three equivalent shapes
//   sel_o, sel_valid_o       lane index offered to the consumer
//   sel_ready_i              consumer took sel_o this cycle
//   sweep_done_o             one-cycle pulse after the last index is taken
module vec_lane_loader
    import vec_lane_pkg::*;
#(
    parameter int unsigned NLANES = 4,
    localparam int unsigned SELW  = sel_width(NLANES)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic              in_bit_i,
    output logic              in_ready_o,
    input  logic              flush_i,
    output logic [NLANES-1:0] lane_vec_o,
    output logic [0:0]        lane_arr_o [NLANES],
    output bit                lane_bit_o [NLANES],
    output logic [SELW-1:0]   sel_o,
    output logic              sel_valid_o,
    input  logic              sel_ready_i,
    output logic              sweep_done_o
);

    // End-of-range index; compared explicitly so non-power-of-2 lane
    // counts never rely on wrap-around.
    localparam logic [SELW-1:0] LastIdx = SELW'(NLANES - 1);

    state_e            state_q;
    logic [SELW-1:0]   count_q;
    logic [SELW-1:0]   sel_q;
    logic              sel_valid_q;
    logic              in_ready_q;
    logic              sweep_done_q;
    logic [NLANES-1:0] lanes_q;

    always_ff @(posedge clk) begin
        sweep_done_q <= 1'b0;
        if (reset || flush_i) begin
            // flush shares the reset effect; a sample offered alongside it is dropped
            state_q     <= StLoad;
            count_q     <= '0;
            sel_q       <= '0;
            sel_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            lanes_q     <= '0;
        end else begin
            unique case (state_q)
                StLoad: begin
                    if (in_valid_i && in_ready_q) begin
                        lanes_q[count_q] <= in_bit_i;
                        if (count_q == LastIdx) begin
                            state_q     <= StScan;
                            count_q     <= '0;
                            sel_q       <= '0;
                            sel_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                        end else begin
                            count_q <= count_q + 1'b1;
                        end
                    end
                end
                StScan: begin
                    if (sel_valid_q && sel_ready_i) begin
                        if (sel_q == LastIdx) begin
                            state_q      <= StLoad;
                            sel_q        <= '0;
                            sel_valid_q  <= 1'b0;
                            in_ready_q   <= 1'b1;
                            sweep_done_q <= 1'b1;
                        end else begin
                            sel_q <= sel_q + 1'b1;
                        end
                    end
                end
                default: state_q <= StLoad;
            endcase
        end
    end

    assign in_ready_o   = in_ready_q;
    assign sel_o        = sel_q;
    assign sel_valid_o  = sel_valid_q;
    assign sweep_done_o = sweep_done_q;

    vec_lane_fanout #(
        .NLANES (NLANES)
    ) u_fanout (
        .lanes_i    (lanes_q),
        .lane_vec_o (lane_vec_o),
        .lane_arr_o (lane_arr_o),
        .lane_bit_o (lane_bit_o)
    );

endmodule

// File: tb/tb_vec_lane_loader.sv
// Bench for vec_lane_loader: a 4-lane and a 3-lane instance share the same
// stimulus; a per-instance behavioural model predicts every output.
module tb_vec_lane_loader;

    logic clk;
    logic reset, in_valid, in_bit, flush, sel_ready;

    logic       ir4, sv4, sd4;
    logic [3:0] lv4;
    logic [0:0] la4 [4];
    bit         lb4 [4];
    logic [1:0] sel4;

    logic       ir3, sv3, sd3;
    logic [2:0] lv3;
    logic [0:0] la3 [3];
    bit         lb3 [3];
    logic [1:0] sel3;

    int checks = 0;
    int errors = 0;

    // Model state per instance: [0] is 4 lanes, [1] is 3 lanes.
    int nl   [2] = '{4, 3};
    int mbuf [2];
    int mcnt [2];
    int msel [2];
    bit mscan[2];
    bit mdone[2];

    vec_lane_loader #(.NLANES(4)) u_dut4 (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_bit_i     (in_bit),
        .in_ready_o   (ir4),
        .flush_i      (flush),
        .lane_vec_o   (lv4),
        .lane_arr_o   (la4),
        .lane_bit_o   (lb4),
        .sel_o        (sel4),
        .sel_valid_o  (sv4),
        .sel_ready_i  (sel_ready),
        .sweep_done_o (sd4)
    );

    vec_lane_loader #(.NLANES(3)) u_dut3 (
        .clk          (clk),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_bit_i     (in_bit),
        .in_ready_o   (ir3),
        .flush_i      (flush),
        .lane_vec_o   (lv3),
        .lane_arr_o   (la3),
        .lane_bit_o   (lb3),
        .sel_o        (sel3),
        .sel_valid_o  (sv3),
        .sel_ready_i  (sel_ready),
        .sweep_done_o (sd3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Model of one clock edge for instance k, written from the loader's rules.
    task automatic model_edge(input int k, input bit r, input bit f, input bit v,
                              input bit b, input bit s);
        mdone[k] = 1'b0;
        if (r || f) begin
            mbuf[k] = 0; mcnt[k] = 0; msel[k] = 0; mscan[k] = 1'b0;
        end else if (!mscan[k]) begin
            if (v) begin
                if (b) mbuf[k] = mbuf[k] | (1 << mcnt[k]);
                else   mbuf[k] = mbuf[k] & ~(1 << mcnt[k]);
                mcnt[k]++;
                if (mcnt[k] == nl[k]) begin
                    mcnt[k] = 0; msel[k] = 0; mscan[k] = 1'b1;
                end
            end
        end else if (s) begin
            if (msel[k] == nl[k] - 1) begin
                msel[k] = 0; mscan[k] = 1'b0; mdone[k] = 1'b1;
            end else begin
                msel[k]++;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [31:0] a4, b4, a3, b3;
        a4 = '0; b4 = '0; a3 = '0; b3 = '0;
        for (int i = 0; i < 4; i++) begin a4[i] = la4[i][0]; b4[i] = lb4[i]; end
        for (int i = 0; i < 3; i++) begin a3[i] = la3[i][0]; b3[i] = lb3[i]; end
        check({tag, " n4 lane_vec"},   32'(lv4),  mbuf[0]);
        check({tag, " n4 lane_arr"},   a4,        mbuf[0]);
        check({tag, " n4 lane_bit"},   b4,        mbuf[0]);
        check({tag, " n4 sel"},        32'(sel4), msel[0]);
        check({tag, " n4 sel_valid"},  32'(sv4),  32'(mscan[0]));
        check({tag, " n4 in_ready"},   32'(ir4),  32'(!mscan[0]));
        check({tag, " n4 sweep_done"}, 32'(sd4),  32'(mdone[0]));
        check({tag, " n3 lane_vec"},   32'(lv3),  mbuf[1]);
        check({tag, " n3 lane_arr"},   a3,        mbuf[1]);
        check({tag, " n3 lane_bit"},   b3,        mbuf[1]);
        check({tag, " n3 sel"},        32'(sel3), msel[1]);
        check({tag, " n3 sel_valid"},  32'(sv3),  32'(mscan[1]));
        check({tag, " n3 in_ready"},   32'(ir3),  32'(!mscan[1]));
        check({tag, " n3 sweep_done"}, 32'(sd3),  32'(mdone[1]));
    endtask

    // Drive one cycle of inputs, advance the model, then check after the edge.
    task automatic step(input string tag, input bit r, input bit f, input bit v,
                        input bit b, input bit s);
        reset = r; flush = f; in_valid = v; in_bit = b; sel_ready = s;
        model_edge(0, r, f, v, b, s);
        model_edge(1, r, f, v, b, s);
        @(posedge clk);
        #1;
        compare_all(tag);
    endtask

    initial begin
        bit ld [4];
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_bit = 1'b0; sel_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            mbuf[k] = 0; mcnt[k] = 0; msel[k] = 0; mscan[k] = 1'b0; mdone[k] = 1'b0;
        end
        @(negedge clk);

        // Reset values.
        step("reset", 1, 0, 0, 0, 0);

        // Load 1,0,1,1 then full sweep with sel_ready high.
        ld = '{1, 0, 1, 1};
        for (int i = 0; i < 4; i++) step("load1101", 0, 0, 1, ld[i], 1);
        check("load1101 vec", 32'(lv4), 32'h0000_000d);
        check("load1101 sel_valid", 32'(sv4), 32'd1);
        for (int i = 0; i < 4; i++) step("sweep", 0, 0, 0, 0, 1);
        check("sweep done pulse", 32'(sd4), 32'd1);
        check("sweep in_ready", 32'(ir4), 32'd1);
        step("after_done", 0, 0, 0, 0, 1);
        check("done one cycle", 32'(sd4), 32'd0);

        // Backpressure at sel=2.
        step("bp_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("bp_load", 0, 0, 1, 1'($urandom), 0);
        step("bp_adv", 0, 0, 0, 0, 1);
        step("bp_adv", 0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step("bp_hold", 0, 0, 0, 0, 0);
        check("bp sel held", 32'(sel4), 32'd2);
        check("bp valid held", 32'(sv4), 32'd1);
        step("bp_rel", 0, 0, 0, 0, 1);
        step("bp_rel", 0, 0, 0, 0, 1);
        check("bp done", 32'(sd4), 32'd1);

        // in_valid ignored during SCAN after loading 0000.
        step("ign_rst", 1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step("ign_load", 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step("ign_scan", 0, 0, 1, 1, 0);
        for (int i = 0; i < 4; i++) step("ign_sweep", 0, 0, 1, 1, 1);
        check("ign vec", 32'(lv4), 32'd0);

        // Flush after two samples, then load 0,1,1,0.
        step("fl_rst", 1, 0, 0, 0, 0);
        step("fl_pre", 0, 0, 1, 1, 0);
        step("fl_pre", 0, 0, 1, 1, 0);
        step("flush", 0, 1, 1, 1, 0);
        check("flush vec", 32'(lv4), 32'd0);
        ld = '{0, 1, 1, 0};
        for (int i = 0; i < 4; i++) step("fl_load", 0, 0, 1, ld[i], 0);
        check("fl vec 0110", 32'(lv4), 32'h0000_0006);
        step("fl_scan_flush", 0, 1, 0, 0, 1);
        check("flush scan no done", 32'(sd4), 32'd0);

        // Reset mid-sweep at sel=1.
        for (int i = 0; i < 4; i++) step("mid_load", 0, 0, 1, 1, 0);
        step("mid_adv", 0, 0, 0, 0, 1);
        check("mid sel", 32'(sel4), 32'd1);
        step("mid_reset", 1, 0, 0, 0, 1);
        check("mid sel_valid", 32'(sv4), 32'd0);
        check("mid in_ready", 32'(ir4), 32'd1);
        check("mid vec", 32'(lv4), 32'd0);
        check("mid no done", 32'(sd4), 32'd0);

        // Three-lane instance: load 1,1,0 and sweep 0,1,2.
        step("n3_rst", 1, 0, 0, 0, 0);
        step("n3_load", 0, 0, 1, 1, 0);
        step("n3_load", 0, 0, 1, 1, 0);
        step("n3_load", 0, 0, 1, 0, 0);
        check("n3 vec 011", 32'(lv3), 32'h0000_0003);
        for (int i = 0; i < 3; i++) begin
            check("n3 sweep sel", 32'(sel3), 32'(i));
            step("n3_sweep", 0, 0, 0, 0, 1);
        end
        check("n3 done", 32'(sd3), 32'd1);
        check("n3 in_ready", 32'(ir3), 32'd1);

        // Randomized traffic against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand", ($urandom_range(63) == 0), ($urandom_range(31) == 0),
                 ($urandom_range(3) != 0), 1'($urandom), 1'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
